dcache_ecc_way_bank: RTL and testbench
======================================

Name: dcache_ecc_way_bank

Overview:
- Memory-side responder for one data-cache way. It sits behind the tag/ECC arbiter and serves its per-way req/we/addr/be/wdata interface with fixed 1-cycle read latency.
- Line data is stored as Hsiao-encoded words and returned still encoded; the arbiter decodes. Tag, valid and dirty are stored unprotected.
- A background scrubber walks the index space during idle cycles. It corrects single-bit errors in place and counts uncorrectable ones, always yielding to arbiter traffic.

Parameters:
- NumLines, 256, lines in the way (power of two, >=2); IndexWidth = $clog2(NumLines).
- UnprotectedWidth, 128, line data bits before encoding.
- ProtectedWidth, 137, encoded line data bits (hsiao_ecc_enc/dec with DataWidth=UnprotectedWidth).
- TagWidth, 44, tag bits.
- CntWidth, 16, width of the saturating error counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  access request; always accepted, no gnt
- we_i  in  1  1=write, 0=read
- addr_i  in  IndexWidth  line index
- wdata_data_i  in  ProtectedWidth  encoded line data
- wdata_tag_i  in  TagWidth  tag
- wdata_valid_i  in  1  valid bit
- wdata_dirty_i  in  1  dirty bit
- be_data_i  in  1  write whole encoded data field
- be_tag_i  in  1  write tag
- be_vldrty_i  in  1  write valid and dirty
- rvalid_o  out  1  read data valid (one cycle after read req)
- rdata_data_o  out  ProtectedWidth  stored encoded data
- rdata_tag_o  out  TagWidth  stored tag
- rdata_valid_o  out  1  stored valid
- rdata_dirty_o  out  1  stored dirty
- scrub_trigger_i  in  1  level enable for scrubbing
- scrub_busy_o  out  1  scrub FSM not in IDLE
- corrected_o  out  1  1-cycle pulse on scrub write-back of a corrected line
- uncorrectable_o  out  1  1-cycle pulse on double-bit detection
- corr_cnt_o  out  CntWidth  saturating corrected count
- uncorr_cnt_o  out  CntWidth  saturating uncorrectable count

Behaviour:
- Reset (rst_i high, asynchronous):
  - Every storage entry is cleared to 0; all-zero data is a valid codeword.
  - Scrub pointer = 0, FSM = IDLE, counters = 0.
  - All outputs are 0.
- Single-ported storage, one access per cycle. Priority: arbiter request > scrub write-back > scrub read.
- Arbiter read (req_i & ~we_i) at cycle N:
  - rvalid_o = 1 in N+1 with the entry contents.
  - rdata_* hold their value until the next storage read, which may be a scrub read. rdata_* are meaningful only while rvalid_o is high.
- Arbiter write (req_i & we_i):
  - Each field is updated only if its be bit is set; the entry is visible to a read issued the next cycle.
  - rvalid_o stays 0.
- Scrub FSM states IDLE, CHECK, WRITE:
  - IDLE: if scrub_trigger_i & ~req_i, read the entry at the pointer and go to CHECK. Otherwise stay.
  - CHECK: decode the read data (err[0] = single, err[1] = double).
    - If req_i & we_i & be_data_i & addr_i==ptr: drop the result, ptr++, go to IDLE.
    - Else, no error: ptr++, go to IDLE.
    - Else, double error: uncorrectable_o pulse, uncorr_cnt++, ptr++, go to IDLE.
    - Else, single error: re-encode the corrected data into a holding register, go to WRITE.
  - WRITE:
    - If req_i & we_i & be_data_i & addr_i==ptr: abort with no count, ptr++, go to IDLE.
    - Else if req_i: stay in WRITE.
    - Else: write the data field only; corrected_o pulse, corr_cnt++, ptr++, go to IDLE.
  - Dropping scrub_trigger_i only blocks new starts in IDLE; a scrub already in CHECK or WRITE completes.
- Pointer wraps from NumLines-1 to 0. Counters saturate at all-ones.
- Scrubbing never alters tag, valid or dirty.
- An arbiter read in the CHECK cycle is served normally. The decode uses the storage output sampled in that cycle.

Test Plan:
- Write idx 5 (all be=1, data=enc(0x1234...), tag=0xABC, v=1, d=0); read idx 5 next cycle -> rvalid_o=1 one cycle later with identical fields.
- Partial write idx 5 with only be_vldrty_i=1, d=1 -> later read shows the unchanged tag/data and dirty=1.
- Force a 1-bit flip in entry 3, trigger scrub from ptr=3 with no traffic -> CHECK, WRITE, corrected_o pulse, corr_cnt_o=1; the re-read returns the exact codeword.
- Force a 2-bit flip in entry 7 -> uncorrectable_o pulse, uncorr_cnt_o=1; the entry is untouched.
- Single-bit error at ptr=9 with a continuous arbiter read stream during WRITE -> FSM holds in WRITE, then writes back in the first idle cycle.
- Arbiter full-data write to idx 9 during WRITE for ptr=9 -> no write-back, corr_cnt_o unchanged, the stored value is the arbiter's; reset mid-scrub -> FSM=IDLE and counters=0 immediately.

Source files
------------

// File: rtl/dcache_ecc_way_bank.sv
// Storage bank for one data-cache way: Hsiao-encoded line data plus raw tag/valid/dirty,
// single-ported with 1-cycle reads, and an idle-cycle scrubber that repairs single-bit errors.
module dcache_ecc_way_bank #(
  parameter int NumLines         = 256,
  parameter int UnprotectedWidth = 128,
  parameter int ProtectedWidth   = 137,
  parameter int TagWidth         = 44,
  parameter int CntWidth         = 16,
  localparam int IndexWidth      = $clog2(NumLines)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [IndexWidth-1:0]     addr_i,
  input  logic [ProtectedWidth-1:0] wdata_data_i,
  input  logic [TagWidth-1:0]       wdata_tag_i,
  input  logic                      wdata_valid_i,
  input  logic                      wdata_dirty_i,
  input  logic                      be_data_i,
  input  logic                      be_tag_i,
  input  logic                      be_vldrty_i,
  output logic                      rvalid_o,
  output logic [ProtectedWidth-1:0] rdata_data_o,
  output logic [TagWidth-1:0]       rdata_tag_o,
  output logic                      rdata_valid_o,
  output logic                      rdata_dirty_o,
  input  logic                      scrub_trigger_i,
  output logic                      scrub_busy_o,
  output logic                      corrected_o,
  output logic                      uncorrectable_o,
  output logic [CntWidth-1:0]       corr_cnt_o,
  output logic [CntWidth-1:0]       uncorr_cnt_o
);
  localparam int CheckWidth = ProtectedWidth - UnprotectedWidth;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  // Data-bit columns: odd weights from 3 upward, ascending value within each weight.
  function automatic logic [UnprotectedWidth-1:0][CheckWidth-1:0] gen_cols();
    logic [UnprotectedWidth-1:0][CheckWidth-1:0] cols;
    int n;
    int ones;
    cols = '0;
    n = 0;
    for (int w = 3; w <= CheckWidth; w += 2) begin
      for (int v = 0; v < (1 << CheckWidth); v++) begin
        ones = 0;
        for (int b = 0; b < CheckWidth; b++) ones += (v >> b) & 1;
        if (ones == w && n < UnprotectedWidth) begin
          cols[n] = v[CheckWidth-1:0];
          n++;
        end
      end
    end
    return cols;
  endfunction

  localparam logic [UnprotectedWidth-1:0][CheckWidth-1:0] HCols = gen_cols();

  function automatic logic [ProtectedWidth-1:0] encode(input logic [UnprotectedWidth-1:0] d);
    logic [CheckWidth-1:0] p;
    p = '0;
    for (int i = 0; i < UnprotectedWidth; i++) p ^= HCols[i] & {CheckWidth{d[i]}};
    return {p, d};
  endfunction

  logic [ProtectedWidth-1:0] data_mem [NumLines];
  logic [TagWidth-1:0]       tag_mem  [NumLines];
  logic [NumLines-1:0]       valid_mem;
  logic [NumLines-1:0]       dirty_mem;

  logic [ProtectedWidth-1:0] rdata_data_reg;
  logic [TagWidth-1:0]       rdata_tag_reg;
  logic                      rdata_valid_reg;
  logic                      rdata_dirty_reg;
  logic                      rvalid_reg;

  logic [1:0]                state_reg;
  logic [IndexWidth-1:0]     ptr_reg;
  logic [ProtectedWidth-1:0] hold_reg;
  logic [CntWidth-1:0]       corr_cnt_reg;
  logic [CntWidth-1:0]       uncorr_cnt_reg;
  logic                      corrected_reg;
  logic                      uncorrectable_reg;

  logic                      arb_read;
  logic                      arb_write;
  logic                      scrub_read;
  logic                      scrub_wb;
  logic                      ptr_hit;
  logic [IndexWidth-1:0]     rd_addr;

  assign arb_read   = req_i & ~we_i;
  assign arb_write  = req_i & we_i;
  assign scrub_read = (state_reg == IDLE) & scrub_trigger_i & ~req_i;
  assign scrub_wb   = (state_reg == WRITE) & ~req_i;
  assign ptr_hit    = arb_write & be_data_i & (addr_i == ptr_reg);
  assign rd_addr    = req_i ? addr_i : ptr_reg;

  // Decode works on the registered storage output, i.e. what the scrub read returned.
  logic [ProtectedWidth-1:0]   reenc;
  logic [CheckWidth-1:0]       syndrome;
  logic [UnprotectedWidth-1:0] fixed_data;
  logic                        err_single;
  logic                        err_double;

  assign reenc      = encode(rdata_data_reg[UnprotectedWidth-1:0]);
  assign syndrome   = reenc[ProtectedWidth-1:UnprotectedWidth]
                    ^ rdata_data_reg[ProtectedWidth-1:UnprotectedWidth];
  assign err_single = ^syndrome;
  assign err_double = (|syndrome) & ~err_single;

  generate
    for (genvar gi = 0; gi < UnprotectedWidth; gi++) begin : g_fix
      assign fixed_data[gi] = rdata_data_reg[gi] ^ (syndrome == HCols[gi]);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLines; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
      valid_mem       <= '0;
      dirty_mem       <= '0;
      rdata_data_reg  <= '0;
      rdata_tag_reg   <= '0;
      rdata_valid_reg <= 1'b0;
      rdata_dirty_reg <= 1'b0;
      rvalid_reg      <= 1'b0;
    end else begin
      rvalid_reg <= arb_read;
      if (arb_write) begin
        if (be_data_i) data_mem[addr_i] <= wdata_data_i;
        if (be_tag_i)  tag_mem[addr_i]  <= wdata_tag_i;
        if (be_vldrty_i) begin
          valid_mem[addr_i] <= wdata_valid_i;
          dirty_mem[addr_i] <= wdata_dirty_i;
        end
      end else if (scrub_wb) begin
        data_mem[ptr_reg] <= hold_reg;
      end
      if (arb_read | scrub_read) begin
        rdata_data_reg  <= data_mem[rd_addr];
        rdata_tag_reg   <= tag_mem[rd_addr];
        rdata_valid_reg <= valid_mem[rd_addr];
        rdata_dirty_reg <= dirty_mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      hold_reg          <= '0;
      corr_cnt_reg      <= '0;
      uncorr_cnt_reg    <= '0;
      corrected_reg     <= 1'b0;
      uncorrectable_reg <= 1'b0;
    end else begin
      corrected_reg     <= 1'b0;
      uncorrectable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (scrub_read) state_reg <= CHECK;
        end
        CHECK: begin
          if (ptr_hit || !(err_single || err_double)) begin
            ptr_reg   <= ptr_reg + IndexWidth'(1);
            state_reg <= IDLE;
          end else if (err_double) begin
            uncorrectable_reg <= 1'b1;
            if (uncorr_cnt_reg != '1) uncorr_cnt_reg <= uncorr_cnt_reg + CntWidth'(1);
            ptr_reg   <= ptr_reg + IndexWidth'(1);
            state_reg <= IDLE;
          end else begin
            hold_reg  <= encode(fixed_data);
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (ptr_hit) begin
            ptr_reg   <= ptr_reg + IndexWidth'(1);
            state_reg <= IDLE;
          end else if (!req_i) begin
            corrected_reg <= 1'b1;
            if (corr_cnt_reg != '1) corr_cnt_reg <= corr_cnt_reg + CntWidth'(1);
            ptr_reg   <= ptr_reg + IndexWidth'(1);
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rvalid_o        = rvalid_reg;
  assign rdata_data_o    = rdata_data_reg;
  assign rdata_tag_o     = rdata_tag_reg;
  assign rdata_valid_o   = rdata_valid_reg;
  assign rdata_dirty_o   = rdata_dirty_reg;
  assign scrub_busy_o    = (state_reg != IDLE);
  assign corrected_o     = corrected_reg;
  assign uncorrectable_o = uncorrectable_reg;
  assign corr_cnt_o      = corr_cnt_reg;
  assign uncorr_cnt_o    = uncorr_cnt_reg;

endmodule

// File: tb/tb_dcache_ecc_way_bank.sv
// Directed bench for dcache_ecc_way_bank: arbiter reads/writes, scrub correction,
// double-error detection, write-back stalling, abort and asynchronous reset.
module tb_dcache_ecc_way_bank;
  localparam int PW = 137;
  localparam int UW = 128;
  localparam int TW = 44;
  localparam int CW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [PW-1:0] wdata_data = '0;
  logic [TW-1:0] wdata_tag = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_dirty = 1'b0;
  logic          be_data = 1'b0;
  logic          be_tag = 1'b0;
  logic          be_vldrty = 1'b0;
  logic          scrub_trigger = 1'b0;
  logic          rvalid;
  logic [PW-1:0] rdata_data;
  logic [TW-1:0] rdata_tag;
  logic          rdata_valid;
  logic          rdata_dirty;
  logic          scrub_busy;
  logic          corrected;
  logic          uncorrectable;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] cw5, cw3, bad3, cw7, bad7, cw9, bad9, cwy;

  dcache_ecc_way_bank dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_data_i(wdata_data), .wdata_tag_i(wdata_tag),
    .wdata_valid_i(wdata_valid), .wdata_dirty_i(wdata_dirty),
    .be_data_i(be_data), .be_tag_i(be_tag), .be_vldrty_i(be_vldrty),
    .rvalid_o(rvalid), .rdata_data_o(rdata_data), .rdata_tag_o(rdata_tag),
    .rdata_valid_o(rdata_valid), .rdata_dirty_o(rdata_dirty),
    .scrub_trigger_i(scrub_trigger), .scrub_busy_o(scrub_busy),
    .corrected_o(corrected), .uncorrectable_o(uncorrectable),
    .corr_cnt_o(corr_cnt), .uncorr_cnt_o(uncorr_cnt)
  );

  always #5 clk = ~clk;

  // Reference Hsiao(137,128): data columns are the 9-bit odd-weight values (weight 3, then 5)
  // in ascending order; check bits sit above the data bits.
  function automatic logic [PW-1:0] enc(input logic [UW-1:0] d);
    logic [8:0] cols [UW];
    logic [8:0] p;
    logic [8:0] vv;
    int n;
    n = 0;
    p = '0;
    for (int w = 3; w <= 9; w += 2)
      for (int v = 0; v < 512; v++) begin
        vv = v[8:0];
        if (n < UW && $countones(vv) == w) begin
          cols[n] = vv;
          n++;
        end
      end
    for (int i = 0; i < UW; i++) if (d[i]) p = p ^ cols[i];
    return {p, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [PW-1:0] dt, input logic [TW-1:0] tg,
                          input logic v, input logic dy, input logic bd, input logic bt, input logic bv);
    req = 1'b1; we = 1'b1; addr = a; wdata_data = dt; wdata_tag = tg;
    wdata_valid = v; wdata_dirty = dy; be_data = bd; be_tag = bt; be_vldrty = bv;
    tick();
    req = 1'b0; we = 1'b0; be_data = 1'b0; be_tag = 1'b0; be_vldrty = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (rdata_data !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata_data); end
    checks++; if (scrub_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", scrub_busy); end
    checks++; if ({corrected, uncorrectable} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {corrected, uncorrectable}); end
    checks++; if ({corr_cnt, uncorr_cnt} !== '0) begin errors++; $display("FAIL reset_counts: got %h expected 0", {corr_cnt, uncorr_cnt}); end
  endtask

  task automatic test_write_read;
    do_write(8'd5, cw5, 44'hABC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %b expected 0", rvalid); end
    do_read(8'd5);
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid: got %b expected 1", rvalid); end
    checks++; if (rdata_data !== cw5) begin errors++; $display("FAIL read_data: got %h expected %h", rdata_data, cw5); end
    checks++; if (rdata_tag !== 44'hABC) begin errors++; $display("FAIL read_tag: got %h expected abc", rdata_tag); end
    checks++; if ({rdata_valid, rdata_dirty} !== 2'b10) begin errors++; $display("FAIL read_vd: got %b expected 10", {rdata_valid, rdata_dirty}); end
  endtask

  task automatic test_partial_write;
    do_write(8'd5, '1, 44'h555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    do_read(8'd5);
    checks++; if (rdata_data !== cw5) begin errors++; $display("FAIL partial_data: got %h expected %h", rdata_data, cw5); end
    checks++; if (rdata_tag !== 44'hABC) begin errors++; $display("FAIL partial_tag: got %h expected abc", rdata_tag); end
    checks++; if ({rdata_valid, rdata_dirty} !== 2'b11) begin errors++; $display("FAIL partial_vd: got %b expected 11", {rdata_valid, rdata_dirty}); end
  endtask

  task automatic test_back_to_back;
    req = 1'b1; we = 1'b0; addr = 8'd5;
    tick();
    checks++; if (rvalid !== 1'b1 || rdata_data !== cw5) begin errors++; $display("FAIL b2b_first: got %b/%h expected 1/%h", rvalid, rdata_data, cw5); end
    addr = 8'd0;
    tick();
    checks++; if (rvalid !== 1'b1 || rdata_data !== '0 || rdata_dirty !== 1'b0) begin errors++; $display("FAIL b2b_second: got %b/%h/%b expected 1/0/0", rvalid, rdata_data, rdata_dirty); end
    req = 1'b0;
    tick();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", rvalid); end
  endtask

  task automatic test_scrub_single;
    int n;
    logic seen;
    logic stray;
    bad3 = cw3;
    bad3[40] = ~bad3[40];
    do_write(8'd3, bad3, 44'h3C3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    scrub_trigger = 1'b1;
    n = 0; seen = 1'b0; stray = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (uncorrectable) stray = 1'b1;
      if (corrected) seen = 1'b1;
    end
    scrub_trigger = 1'b0;
    // entries 0..2 take two cycles each, entry 3 takes read, check, write
    checks++; if (!seen || n != 9) begin errors++; $display("FAIL single_pulse: got seen=%b at cycle %0d expected seen=1 at cycle 9", seen, n); end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL single_no_uncorr: got %b expected 0", stray); end
    checks++; if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL single_counts: got %0d/%0d expected 1/0", corr_cnt, uncorr_cnt); end
    do_read(8'd3);
    checks++; if (rdata_data !== cw3) begin errors++; $display("FAIL single_fixed: got %h expected %h", rdata_data, cw3); end
    checks++; if (rdata_tag !== 44'h3C3 || {rdata_valid, rdata_dirty} !== 2'b11) begin errors++; $display("FAIL single_meta: got %h/%b expected 3c3/11", rdata_tag, {rdata_valid, rdata_dirty}); end
  endtask

  task automatic test_scrub_double;
    int n;
    logic seen;
    bad7 = cw7;
    bad7[2] = ~bad7[2];
    bad7[100] = ~bad7[100];
    do_write(8'd7, bad7, 44'h777, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    scrub_trigger = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (uncorrectable) seen = 1'b1;
    end
    scrub_trigger = 1'b0;
    checks++; if (!seen || n != 8) begin errors++; $display("FAIL double_pulse: got seen=%b at cycle %0d expected seen=1 at cycle 8", seen, n); end
    checks++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd1) begin errors++; $display("FAIL double_counts: got %0d/%0d expected 1/1", uncorr_cnt, corr_cnt); end
    tick();
    checks++; if (uncorrectable !== 1'b0 || scrub_busy !== 1'b0) begin errors++; $display("FAIL double_settle: got %b/%b expected 0/0", uncorrectable, scrub_busy); end
    do_read(8'd7);
    checks++; if (rdata_data !== bad7) begin errors++; $display("FAIL double_untouched: got %h expected %h", rdata_data, bad7); end
  endtask

  task automatic test_scrub_stall;
    bad9 = cw9;
    bad9[130] = ~bad9[130];
    do_write(8'd9, bad9, 44'h999, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    scrub_trigger = 1'b1;
    repeat (4) tick();
    scrub_trigger = 1'b0;
    checks++; if (scrub_busy !== 1'b1 || corrected !== 1'b0) begin errors++; $display("FAIL stall_in_write: got busy=%b corr=%b expected 1/0", scrub_busy, corrected); end
    req = 1'b1; we = 1'b0; addr = 8'd5;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rvalid !== 1'b1 || rdata_data !== cw5 || corrected !== 1'b0 || scrub_busy !== 1'b1) begin
        errors++; $display("FAIL stall_cycle%0d: got rv=%b corr=%b busy=%b data=%h expected 1/0/1 %h", k, rvalid, corrected, scrub_busy, rdata_data, cw5);
      end
    end
    req = 1'b0;
    tick();
    checks++; if (corrected !== 1'b1 || corr_cnt !== 16'd2 || scrub_busy !== 1'b0) begin errors++; $display("FAIL stall_writeback: got corr=%b cnt=%0d busy=%b expected 1/2/0", corrected, corr_cnt, scrub_busy); end
    do_read(8'd9);
    checks++; if (rdata_data !== cw9) begin errors++; $display("FAIL stall_fixed: got %h expected %h", rdata_data, cw9); end
  endtask

  task automatic test_reset_mid_scrub;
    scrub_trigger = 1'b1;
    tick();
    scrub_trigger = 1'b0;
    checks++; if (scrub_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", scrub_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (scrub_busy !== 1'b0 || corr_cnt !== '0 || uncorr_cnt !== '0) begin errors++; $display("FAIL midrst_async: got busy=%b cnts=%0d/%0d expected 0/0/0", scrub_busy, corr_cnt, uncorr_cnt); end
    @(negedge clk);
    rst = 1'b0;
    do_read(8'd9);
    checks++; if (rdata_data !== '0 || rdata_tag !== '0) begin errors++; $display("FAIL midrst_cleared: got %h/%h expected 0/0", rdata_data, rdata_tag); end
  endtask

  task automatic test_scrub_abort;
    logic stray;
    bad9 = cw9;
    bad9[7] = ~bad9[7];
    do_write(8'd9, bad9, 44'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    scrub_trigger = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (corrected || uncorrectable) stray = 1'b1;
    end
    scrub_trigger = 1'b0;
    checks++; if (scrub_busy !== 1'b1 || stray !== 1'b0) begin errors++; $display("FAIL abort_reach_write: got busy=%b stray=%b expected 1/0", scrub_busy, stray); end
    do_write(8'd9, cwy, 44'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (scrub_busy !== 1'b0 || corrected !== 1'b0) begin errors++; $display("FAIL abort_exit: got busy=%b corr=%b expected 0/0", scrub_busy, corrected); end
    tick();
    checks++; if (corrected !== 1'b0 || corr_cnt !== '0) begin errors++; $display("FAIL abort_no_count: got corr=%b cnt=%0d expected 0/0", corrected, corr_cnt); end
    do_read(8'd9);
    checks++; if (rdata_data !== cwy) begin errors++; $display("FAIL abort_arb_data: got %h expected %h", rdata_data, cwy); end
  endtask

  initial begin
    cw5 = enc(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
    cw3 = enc(128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef);
    cw7 = enc(128'h0f0f_0f0f_f0f0_f0f0_aaaa_5555_3333_cccc);
    cw9 = enc(128'h8000_0000_0000_0001_7fff_ffff_ffff_fffe);
    cwy = enc(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    tick();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_scrub_single();
    test_scrub_double();
    test_scrub_stall();
    test_reset_mid_scrub();
    test_scrub_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
